dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port 512x32 data memory between the pipeline MEM stage (CPU port)
//  and an external loader/debug port (EXT port). CPU keeps same-cycle async-read timing
//  when granted; EXT gets registered read data. A starvation counter bounds EXT wait
//  time. Sits between the MEM stage and data_file, and drives all memory address/we/din.
// PARAMETERS
//  ADDR_W       10  word address width (1024-word space, 512 words populated)
//  DATA_W       32  data width
//  MAX_CPU_RUN  8   consecutive CPU grants allowed while EXT pending (>=1)
//  LEN_W        4   burst length field width (used only with DMEM_ARB_BURST_EN)
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  cpu_req    in   1       MEM stage load/store this cycle
//  cpu_we     in   1       1=store
//  cpu_addr   in   ADDR_W  word address
//  cpu_wdata  in   DATA_W  store data
//  cpu_rdata  out  DATA_W  load data, same cycle, valid when cpu_req & ~cpu_stall
//  cpu_stall  out  1       hold the pipeline; access not performed this cycle
//  ext_req    in   1       EXT access request, held until ext_gnt
//  ext_we     in   1       1=write
//  ext_addr   in   ADDR_W  word address (burst base when burst enabled)
//  ext_wdata  in   DATA_W  write data, sampled in each ext_gnt cycle
//  ext_len    in   LEN_W   burst beats minus 1 (ignored without DMEM_ARB_BURST_EN)
//  ext_gnt    out  1       beat accepted this cycle
//  ext_rvalid out  1       read data valid, 1 cycle after a read ext_gnt
//  ext_rdata  out  DATA_W  registered read data
//  mem_addr   out  ADDR_W  to data memory
//  mem_we     out  1       to data memory
//  mem_din    out  DATA_W  to data memory
//  mem_dout   in   DATA_W  async read data from memory
// BEHAVIOUR
//  - Reset: state IDLE, starve_cnt=0, ext_rvalid=0, ext_rdata=0; combinational outputs
//    follow reset state: ext_gnt=0, mem_we=0, cpu_stall=cpu_req & ext owner (none at reset).
//  - Per-cycle owner (combinational from state): EXT if state==EXT_BURST, else EXT if
//    ext_req & (~cpu_req | starve_cnt==MAX_CPU_RUN), else CPU if cpu_req, else none.
//  - Owner CPU: mem_* = cpu_*; cpu_rdata=mem_dout; cpu_stall=0.
//  - Owner EXT: mem_* = ext_*; ext_gnt=1; cpu_stall=cpu_req. No owner: mem_we=0,
//    mem_addr=cpu_addr.
//  - mem_we never asserted by a non-owner; mem_we=0 whenever no request is granted.
//  - starve_cnt: +1 on cycles CPU owns while ext_req=1, saturating at MAX_CPU_RUN;
//    cleared on any ext_gnt or when ext_req=0. EXT worst-case wait = MAX_CPU_RUN cycles.
//  - ext_rvalid<=ext_gnt & ~ext_we; ext_rdata<=mem_dout on those cycles, else holds.
//  - Address 0 is overwritten every cycle by the memory's input mirror; writes to it
//    pass through but do not persist (not an arbiter error).
//  - Reset asserted mid-burst: burst aborted, return to IDLE next edge, no further beats.
// CONFIGURATION
//  DMEM_ARB_BURST_EN defined: on first EXT grant latch base=ext_addr, beats=ext_len;
//   if ext_len!=0 enter EXT_BURST; beat k uses addr base+k (wraps mod 2^ADDR_W);
//   ext_gnt every cycle of the burst, CPU stalled throughout; return IDLE after beat
//   ext_len. ext_req need not stay high during burst; ext_addr/ext_len ignored then.
//  Undefined: no EXT_BURST state; every EXT access is a single beat; ext_len unused.
// STRUCTURE
//  dmem_arb_pkg: state enum {IDLE, EXT_BURST}, owner encoding {OWN_NONE, OWN_CPU,
//  OWN_EXT}, default widths. Sub-module dmem_arb_burst_ctr (base/beat counter, last-beat
//  flag), instantiated only under DMEM_ARB_BURST_EN.
// TESTING
//  1 CPU-only: store 0x12345678 @5, load @5 -> cpu_rdata=0x12345678 same cycle, stall=0.
//  2 EXT read idle bus: ext_req, addr 4 -> ext_gnt cycle 0, ext_rvalid+data cycle 1.
//  3 Contention: cpu_req held high, ext_req rises -> CPU owns 8 cycles, EXT gnt on 9th,
//    cpu_stall=1 exactly that cycle, starve_cnt=0 after.
//  4 Simultaneous single request with starve_cnt=0 and cpu_req=1 -> CPU wins, mem_we
//    only from cpu_we; ext write data not in memory.
//  5 BURST_EN: ext write len=3 base 0x3FE -> addresses 0x3FE,0x3FF,0x000,0x001, 4 gnts,
//    CPU stalled 4 cycles; rst at beat 2 -> no write on beat 3, state IDLE.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and default widths for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int c_ADDR_W      = 10;
    localparam int c_DATA_W      = 32;
    localparam int c_LEN_W       = 4;
    localparam int c_MAX_CPU_RUN = 8;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        EXT_BURST = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_t;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : CPU, EXT and memory-side signals of the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int LEN_W  = c_LEN_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic [LEN_W-1:0]  ext_len;
    logic              ext_gnt;
    logic              ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata, ext_len,
        input  mem_dout,
        output cpu_rdata, cpu_stall,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_addr, mem_we, mem_din
    );

    // Requester / memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata, ext_len,
        output mem_dout,
        input  cpu_rdata, cpu_stall,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_addr, mem_we, mem_din
    );

endinterface : dmem_arbiter_if
`default_nettype wire

// File: rtl/dmem_arb_burst_ctr.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_burst_ctr
// Description : Latches EXT burst base/length/direction and steps the beat index.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_burst_ctr
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int LEN_W  = c_LEN_W
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_start,
    input  wire logic              i_advance,
    input  wire logic [ADDR_W-1:0] i_base,
    input  wire logic [LEN_W-1:0]  i_len,
    input  wire logic              i_we,
    output logic      [ADDR_W-1:0] o_addr,
    output logic                   o_last,
    output logic                   o_we
);

    logic [ADDR_W-1:0] r_base_q, w_base_d;
    logic [LEN_W-1:0]  r_len_q,  w_len_d;
    logic [LEN_W-1:0]  r_beat_q, w_beat_d;
    logic              r_we_q,   w_we_d;

    // Beat 0 is issued straight from the request, so the counter starts at 1.
    always_comb begin
        w_base_d = r_base_q;
        w_len_d  = r_len_q;
        w_beat_d = r_beat_q;
        w_we_d   = r_we_q;
        if (i_start) begin
            w_base_d = i_base;
            w_len_d  = i_len;
            w_beat_d = LEN_W'(1);
            w_we_d   = i_we;
        end else if (i_advance) begin
            w_beat_d = r_beat_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base_q <= '0;
            r_len_q  <= '0;
            r_beat_q <= '0;
            r_we_q   <= 1'b0;
        end else begin
            r_base_q <= w_base_d;
            r_len_q  <= w_len_d;
            r_beat_q <= w_beat_d;
            r_we_q   <= w_we_d;
        end
    end

    assign o_addr = r_base_q + ADDR_W'(r_beat_q);
    assign o_last = (r_beat_q == r_len_q);
    assign o_we   = r_we_q;

endmodule : dmem_arb_burst_ctr
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : CPU/EXT arbiter for the single-port data memory with bounded
//               EXT starvation. Define DMEM_ARB_BURST_EN for EXT bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W      = c_ADDR_W,
    parameter int DATA_W      = c_DATA_W,
    parameter int MAX_CPU_RUN = c_MAX_CPU_RUN,
    parameter int LEN_W       = c_LEN_W
) (
    input  wire logic     clk,
    input  wire logic     rst,
    dmem_arbiter_if.slave bus
);

    localparam int                 c_CNT_W   = $clog2(MAX_CPU_RUN + 1);
    localparam logic [c_CNT_W-1:0] c_RUN_MAX = c_CNT_W'(MAX_CPU_RUN);

    owner_t            w_owner;
    logic              w_in_burst;
    logic              w_ext_we;
    logic [ADDR_W-1:0] w_ext_addr;
    logic              w_ext_gnt;
    logic              w_starved;
    logic [c_CNT_W-1:0] r_starve_cnt_q, w_starve_cnt_d;
    logic              r_rvalid_q, w_rvalid_d;
    logic [DATA_W-1:0] r_rdata_q,  w_rdata_d;

`ifdef DMEM_ARB_BURST_EN
    state_t            r_state_q, w_state_d;
    logic              w_start;
    logic              w_burst_last;
    logic              w_burst_we;
    logic [ADDR_W-1:0] w_burst_addr;

    assign w_in_burst = (r_state_q == EXT_BURST);
    assign w_start    = (r_state_q == IDLE) && w_ext_gnt && (bus.ext_len != '0);

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            IDLE:      if (w_start)      w_state_d = EXT_BURST;
            EXT_BURST: if (w_burst_last) w_state_d = IDLE;
            default:                     w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state_q <= IDLE;
        else     r_state_q <= w_state_d;
    end

    dmem_arb_burst_ctr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_burst_ctr (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start),
        .i_advance (w_in_burst),
        .i_base    (bus.ext_addr),
        .i_len     (bus.ext_len),
        .i_we      (bus.ext_we),
        .o_addr    (w_burst_addr),
        .o_last    (w_burst_last),
        .o_we      (w_burst_we)
    );

    assign w_ext_we   = w_in_burst ? w_burst_we   : bus.ext_we;
    assign w_ext_addr = w_in_burst ? w_burst_addr : bus.ext_addr;
`else
    logic w_unused_len;
    assign w_unused_len = ^bus.ext_len;
    assign w_in_burst   = 1'b0;
    assign w_ext_we     = bus.ext_we;
    assign w_ext_addr   = bus.ext_addr;
`endif

    assign w_starved = (r_starve_cnt_q == c_RUN_MAX);

    always_comb begin
        w_owner = OWN_NONE;
        if (w_in_burst)                                   w_owner = OWN_EXT;
        else if (bus.ext_req && (!bus.cpu_req || w_starved)) w_owner = OWN_EXT;
        else if (bus.cpu_req)                             w_owner = OWN_CPU;
    end

    assign w_ext_gnt = (w_owner == OWN_EXT);

    // Non-owners never reach mem_we; idle cycles park the address on the CPU.
    always_comb begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_we    = 1'b0;
        bus.mem_din   = bus.cpu_wdata;
        bus.cpu_stall = 1'b0;
        case (w_owner)
            OWN_CPU: bus.mem_we = bus.cpu_we;
            OWN_EXT: begin
                bus.mem_addr  = w_ext_addr;
                bus.mem_we    = w_ext_we;
                bus.mem_din   = bus.ext_wdata;
                bus.cpu_stall = bus.cpu_req;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_starve_cnt_d = r_starve_cnt_q;
        if (!bus.ext_req || w_ext_gnt)
            w_starve_cnt_d = '0;
        else if ((w_owner == OWN_CPU) && !w_starved)
            w_starve_cnt_d = r_starve_cnt_q + c_CNT_W'(1);
        w_rvalid_d = w_ext_gnt && !w_ext_we;
        w_rdata_d  = w_rvalid_d ? bus.mem_dout : r_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt_q <= '0;
            r_rvalid_q     <= 1'b0;
            r_rdata_q      <= '0;
        end else begin
            r_starve_cnt_q <= w_starve_cnt_d;
            r_rvalid_q     <= w_rvalid_d;
            r_rdata_q      <= w_rdata_d;
        end
    end

    assign bus.cpu_rdata  = bus.mem_dout;
    assign bus.ext_gnt    = w_ext_gnt;
    assign bus.ext_rvalid = r_rvalid_q;
    assign bus.ext_rdata  = r_rdata_q;

endmodule : dmem_arbiter
`default_nettype wire
